// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divider.
//   - div_op_t      : operation encoding, op[0]=1 means unsigned, op[1]=1 means remainder
//   - div_state_t   : divider FSM states
//   - div_special() : RISC-V divide-by-zero / signed-overflow resolution
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  // Widest operand the special-case helper handles; callers zero-extend.
  localparam int unsigned SPEC_W = 64;

  typedef struct packed {
    logic              hit;
    logic [SPEC_W-1:0] value;
  } div_special_t;

  // Resolves the cases RISC-V defines without dividing. Only the low
  // 'width' bits of a, b and the returned value are meaningful.
  function automatic div_special_t div_special(input logic [1:0]        op,
                                               input logic [SPEC_W-1:0] a,
                                               input logic [SPEC_W-1:0] b,
                                               input int unsigned       width);
    logic [SPEC_W-1:0] mask;
    logic [SPEC_W-1:0] min_neg;
    div_special_t      res;
    mask      = (width >= SPEC_W) ? '1 : ((SPEC_W'(1) << width) - SPEC_W'(1));
    min_neg   = SPEC_W'(1) << (width - 1);
    res.hit   = 1'b0;
    res.value = '0;
    if ((b & mask) == '0) begin
      res.hit   = 1'b1;
      res.value = op[1] ? (a & mask) : mask;
    end else if (!op[0] && ((a & mask) == min_neg) && ((b & mask) == mask)) begin
      res.hit   = 1'b1;
      res.value = op[1] ? '0 : min_neg;
    end
    return res;
  endfunction

endpackage

// File: rtl/iter_div_unit_step.sv
// iter_div_unit_step: UNROLL chained restoring-division steps (combinational).
//   i_rem     : partial remainder
//   i_quo     : quotient / remaining dividend bits (shifted out MSB-first)
//   i_divisor : divisor magnitude
//   o_rem     : partial remainder after UNROLL steps
//   o_quo     : quotient register after UNROLL steps
module div_step #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // Remainder stays below the divisor, so bit WIDTH of the trial
  // difference is exactly the borrow.
  always_comb begin
    w_rem   = i_rem;
    w_quo   = i_quo;
    w_shift = '0;
    w_diff  = '0;
    for (int i = 0; i < int'(UNROLL); i++) begin
      w_shift = {w_rem, w_quo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, i_divisor};
      w_quo   = {w_quo[WIDTH-2:0], ~w_diff[WIDTH]};
      w_rem   = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end
  end

  assign o_rem = w_rem;
  assign o_quo = w_quo;

endmodule

// File: rtl/iter_div_unit.sv
// iter_div_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//   CLK, nrst : clock, synchronous active-low reset
//   start     : request, sampled only in IDLE
//   op        : 0=DIV 1=DIVU 2=REM 3=REMU
//   opA, opB  : dividend, divisor
//   kill      : aborts an operation in CALC/FIX; blocks a start in IDLE
//   busy      : combinational stall request
//   done      : registered one-cycle pulse, result valid
//   result    : registered, held until the next done
// Special cases and repeats of the last operands finish in one cycle via
// a one-entry quotient/remainder cache.
module iter_div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic             CLK,
  input  logic             nrst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned ITERS = WIDTH / UNROLL;
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_c_valid;
  logic [WIDTH-1:0] r_c_a;
  logic [WIDTH-1:0] r_c_b;
  logic             r_c_uns;
  logic [WIDTH-1:0] r_c_quo;
  logic [WIDTH-1:0] r_c_rem;

  div_special_t     w_spec;
  logic [WIDTH-1:0] w_spec_val;
  logic             w_unused_spec;
  logic             w_accept;
  logic             w_c_hit;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic [WIDTH-1:0] w_fix_quo;
  logic [WIDTH-1:0] w_fix_rem;

  // Special-case resolution on the raw request operands.
  assign w_spec        = div_special(op, SPEC_W'(opA), SPEC_W'(opB), WIDTH);
  assign w_spec_val    = w_spec.value[WIDTH-1:0];
  assign w_unused_spec = ^w_spec.value;

  assign w_accept = nrst && (r_state == ST_IDLE) && start && !kill;
  assign w_c_hit  = r_c_valid && (opA == r_c_a) && (opB == r_c_b) && (op[0] == r_c_uns);

  // Magnitudes as unsigned WIDTH bits: -(most negative) keeps its bit pattern.
  assign w_a_neg = !op[0] && opA[WIDTH-1];
  assign w_b_neg = !op[0] && opB[WIDTH-1];
  assign w_mag_a = w_a_neg ? (~opA + WIDTH'(1)) : opA;
  assign w_mag_b = w_b_neg ? (~opB + WIDTH'(1)) : opB;

  div_step #(
    .WIDTH  (WIDTH),
    .UNROLL (UNROLL)
  ) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_dvsr),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  assign w_fix_quo = r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_fix_rem = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;

  assign busy   = w_accept || (r_state == ST_CALC) || (r_state == ST_FIX);
  assign done   = r_done;
  assign result = r_result;

  // Divider FSM, datapath and cache.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_c_valid <= 1'b0;
      r_c_a     <= '0;
      r_c_b     <= '0;
      r_c_uns   <= 1'b0;
      r_c_quo   <= '0;
      r_c_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_spec.hit) begin
              r_result <= w_spec_val;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else if (w_c_hit) begin
              r_result <= op[1] ? r_c_rem : r_c_quo;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_op    <= op;
              r_a     <= opA;
              r_b     <= opB;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_quo   <= w_mag_a;
              r_dvsr  <= w_mag_b;
              r_rem   <= '0;
              r_cnt   <= CNT_LOAD;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (kill) begin
            r_c_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            if (r_cnt == '0) begin
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        ST_FIX: begin
          if (kill) begin
            r_c_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_c_valid <= 1'b1;
            r_c_a     <= r_a;
            r_c_b     <= r_b;
            r_c_uns   <= r_op[0];
            r_c_quo   <= w_fix_quo;
            r_c_rem   <= w_fix_rem;
            r_result  <= r_op[1] ? w_fix_rem : w_fix_quo;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/iter_div_unit.md
# iter_div_unit

Parametrised iterative restoring divider for the EXE stage. It implements RV32M DIV/DIVU/REM/REMU without vendor IP. Width and bits-per-cycle are configurable. RISC-V special cases are resolved in one cycle, and the last quotient/remainder pair is cached so that a DIV followed by a REM (or the reverse) on the same operands completes in one cycle. The pipeline stall logic consumes `busy` the same way it consumes the existing divider-running signal.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must be even and ≥ 8.
- `UNROLL`, 1: quotient bits retired per cycle; one of 1, 2, 4; must divide `WIDTH`.

Ports:
- `CLK`  in  1  clock.
- `nrst`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU; `op[0]`=1 means unsigned.
- `opA`  in  WIDTH  dividend.
- `opB`  in  WIDTH  divisor.
- `kill`  in  1  pipeline flush; aborts the operation in flight.
- `busy`  out  1  combinational; high in IDLE when `start` is accepted, and in every non-IDLE state except DONE.
- `done`  out  1  registered one-cycle pulse; `result` is valid in that cycle.
- `result`  out  WIDTH  registered; holds its value until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE + start, special case or cache hit**: write `result` and go to DONE. `busy` is high for that cycle only.
  - Divide-by-zero: DIV/DIVU → all-ones; REM/REMU → opA.
  - Signed overflow (signed op, opA = 1<<(WIDTH-1), opB = all-ones): DIV → opA; REM → 0.
  - Cache hit: same opA, opB and signedness as the valid cache entry. Return the cached quotient (DIV/DIVU) or remainder (REM/REMU).
- **IDLE + start, normal case**:
  - Latch op, the sign flags and the operand magnitudes (absolute values if signed).
  - Clear the partial remainder; load the iteration counter with `WIDTH/UNROLL - 1`.
  - Go to CALC.
- **CALC**:
  - Each cycle performs `UNROLL` restoring steps: shift {rem,quo} left by 1; trial subtract the divisor magnitude; if there is no borrow, keep the difference and set the quotient LSB.
  - Go to FIX when the counter reaches 0.
- **FIX**:
  - Negate the quotient if the operand signs differ (signed ops only).
  - Negate the remainder if the dividend was negative (signed ops only).
  - Write the cache: opA, opB, signedness, quotient, remainder, valid=1. Write `result` according to op.
  - Go to DONE.
- **DONE**: `done`=1. Go to IDLE. `start` in DONE is ignored; the requester reissues it in IDLE.
- **kill** in CALC or FIX: go to IDLE next cycle; no `done`; cache valid cleared; `result` unchanged.
  - `kill` in IDLE blocks acceptance of a simultaneous `start`.
  - `kill` in DONE is ignored.
- `start` while not in IDLE is ignored.
- Arithmetic: trial subtraction is `WIDTH+1` bits wide. Magnitudes are held as unsigned `WIDTH` bits, so the negated most-negative value stays correct.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, cache valid 0, counter 0.
- `nrst` low in any state takes priority over `start` and `kill`. It returns to IDLE next cycle and no `done` is issued.
- Normal latency: `start` sampled at edge 0; CALC occupies `WIDTH/UNROLL` cycles; FIX one cycle; `done` high in cycle `WIDTH/UNROLL + 2`. For WIDTH=32, UNROLL=1, `done` is high in cycle 34.
- Special case or cache hit: `done` high in cycle 1.
- `busy` falls in the DONE cycle, so the pipeline advances on the same edge that `result` is consumed.
- Back-to-back: the earliest next accept is the cycle after DONE (IDLE).

## Structure
- Package `div_pkg`:
  - op encodings `DIV`/`DIVU`/`REM`/`REMU`;
  - state enum `div_state_t`;
  - function `div_special(op, a, b)` returning {hit, value}.
- Sub-module `div_step`: combinational chain of `UNROLL` restoring steps. Inputs: {rem, quo, divisor}; outputs: {rem', quo'}. Instantiated once.
- The top level holds the FSM, counter, sign handling and cache registers.

## Test plan
- DIV −7 / 2 (opA=0xFFFFFFF9, opB=2), UNROLL=1 → `done` at cycle 34 with `result`=0xFFFFFFFD. An immediately following REM on the same operands → `done` at cycle 1 with `result`=0xFFFFFFFF (cache hit).
- DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF. Then REMU with opB changed to 0x11 → full latency (cache miss), `result`=0x0.
- Special cases, each with `done` at cycle 1:
  - DIV x/0 → 0xFFFFFFFF;
  - REMU 0x1234/0 → 0x1234;
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000;
  - REM of the same operands → 0.
- `kill` at CALC cycle 10 → no `done`, `busy` low next cycle. A following REM on the same operands runs full latency (cache invalidated).
- `nrst` low mid-CALC → next cycle: state IDLE, `busy`=0, `result`=0. `start` asserted in the same cycle as `nrst` low is not accepted.
- UNROLL=4, WIDTH=32: random signed/unsigned sweep checked against a reference model; `done` at cycle 10 for normal cases.
